ladybird_bus_decoder: RTL and testbench

- Parametrised N-target address decoder/router between one core bus master (I or D port) and N peripheral targets; it generalises the fixed ROM/DRAM/GPIO decode into a programmable region table.
- Registers the forwarded request and tracks outstanding transactions in an in-order ID FIFO so that responses return in request order.
- Generates a decode-error response for unmapped addresses and flags uncachable regions for the L1 caches.

---
 rtl/ladybird_bus_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ladybird_bus_decoder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_bus_decoder
// Brief    : N-target address decoder/router with in-order response return
//            and decode-error generation for unmapped addresses.
// Revision : 1.0
// ============================================================================

module ladybird_bus_decoder #(
    parameter int N_TARGET        = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [N_TARGET*ADDR_W-1:0] REGION_BASE =
        {32'h10000000, 32'h80000000, 32'h02000000, 32'h00001000},
    parameter logic [N_TARGET*ADDR_W-1:0] REGION_MASK =
        {32'hFFFFF000, 32'h80000000, 32'hFFFF0000, 32'hFFFFF000},
    parameter logic [N_TARGET-1:0] REGION_UNCACHABLE = 4'b1010
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         req_write,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_wstrb,
    output logic                         req_uncachable,

    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         resp_error,

    output logic [N_TARGET-1:0]          t_req_valid,
    input  logic [N_TARGET-1:0]          t_req_ready,
    output logic [ADDR_W-1:0]            t_req_addr,
    output logic                         t_req_write,
    output logic [DATA_W-1:0]            t_req_wdata,
    output logic [DATA_W/8-1:0]          t_req_wstrb,

    input  logic [N_TARGET-1:0]          t_resp_valid,
    output logic [N_TARGET-1:0]          t_resp_ready,
    input  logic [N_TARGET*DATA_W-1:0]   t_resp_data
);

    localparam int TGT_W  = (N_TARGET > 1) ? $clog2(N_TARGET) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [N_TARGET-1:0] w_hit;
    logic [TGT_W-1:0]    w_dec_tgt;
    logic                w_mapped;
    logic [DATA_W-1:0]   w_t_data [N_TARGET];

    logic                r_slot_valid;
    logic [TGT_W-1:0]    r_slot_tgt;

    generate
        for (genvar gi = 0; gi < N_TARGET; gi++) begin : g_target
            localparam logic [ADDR_W-1:0] c_base = REGION_BASE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] c_mask = REGION_MASK[gi*ADDR_W +: ADDR_W];

            assign w_hit[gi]       = ((req_addr & c_mask) == (c_base & c_mask));
            assign t_req_valid[gi] = r_slot_valid && (r_slot_tgt == TGT_W'(gi));
            assign w_t_data[gi]    = t_resp_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Walk downward so the lowest-index hit is the one left standing.
    always_comb begin
        w_dec_tgt = '0;
        for (int i = N_TARGET - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_dec_tgt = TGT_W'(i);
            end
        end
    end

    assign w_mapped       = |w_hit;
    assign req_uncachable = w_mapped ? REGION_UNCACHABLE[w_dec_tgt] : 1'b1;

    // ------------------------------------------------------------------
    // Request slot and upstream handshake
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [CNT_W-1:0]  r_count;

    logic w_slot_free;
    logic w_fifo_room;
    logic w_accept;
    logic w_load;
    logic w_pop;

    assign w_slot_free = !r_slot_valid || t_req_ready[r_slot_tgt];
    // Registered count only: a pop in this cycle does not open space until next.
    assign w_fifo_room = (r_count < c_max_cnt);
    assign req_ready   = w_slot_free && w_fifo_room;
    assign w_accept    = req_valid && req_ready;
    assign w_load      = w_accept && w_mapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_valid <= 1'b0;
            r_slot_tgt   <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else if (w_load) begin
            r_slot_valid <= 1'b1;
            r_slot_tgt   <= w_dec_tgt;
            r_addr       <= req_addr;
            r_write      <= req_write;
            r_wdata      <= req_wdata;
            r_wstrb      <= req_wstrb;
        end else if (r_slot_valid && t_req_ready[r_slot_tgt]) begin
            r_slot_valid <= 1'b0;
        end
    end

    assign t_req_addr  = r_addr;
    assign t_req_write = r_write;
    assign t_req_wdata = r_wdata;
    assign t_req_wstrb = r_wstrb;

    // ------------------------------------------------------------------
    // In-order ID FIFO: target index plus an error tag for unmapped accesses
    // ------------------------------------------------------------------
    logic [TGT_W-1:0]           r_fifo_tgt [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] r_fifo_err;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;

    logic             w_empty;
    logic [TGT_W-1:0] w_head_tgt;
    logic             w_head_err;

    assign w_empty    = (r_count == '0);
    assign w_head_tgt = r_fifo_tgt[r_rd_ptr];
    assign w_head_err = r_fifo_err[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo_tgt[r_wr_ptr] <= w_dec_tgt;
            r_fifo_err[r_wr_ptr] <= !w_mapped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response steering: only the FIFO head may complete
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid   = 1'b0;
        resp_data    = '0;
        resp_error   = 1'b0;
        t_resp_ready = '0;
        if (!w_empty) begin
            if (w_head_err) begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
            end else begin
                resp_valid               = t_resp_valid[w_head_tgt];
                resp_data                = w_t_data[w_head_tgt];
                t_resp_ready[w_head_tgt] = resp_ready;
            end
        end
    end

    assign w_pop = resp_valid && resp_ready;

endmodule

`default_nettype wire

// File: tb/tb_ladybird_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ladybird_bus_decoder
// Brief    : Scenario tests with a response scoreboard for ladybird_bus_decoder.
// Revision : 1.0
// ============================================================================

module tb_ladybird_bus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_write;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         req_uncachable;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic         resp_error;
    logic [3:0]   t_req_valid;
    logic [3:0]   t_req_ready;
    logic [31:0]  t_req_addr;
    logic         t_req_write;
    logic [31:0]  t_req_wdata;
    logic [3:0]   t_req_wstrb;
    logic [3:0]   t_resp_valid;
    logic [3:0]   t_resp_ready;
    logic [127:0] t_resp_data;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ladybird_bus_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .req_uncachable (req_uncachable),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_error     (resp_error),
        .t_req_valid    (t_req_valid),
        .t_req_ready    (t_req_ready),
        .t_req_addr     (t_req_addr),
        .t_req_write    (t_req_write),
        .t_req_wdata    (t_req_wdata),
        .t_req_wstrb    (t_req_wstrb),
        .t_resp_valid   (t_resp_valid),
        .t_resp_ready   (t_resp_ready),
        .t_resp_data    (t_resp_data)
    );

    function automatic exp_t mk(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        return x;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Upstream completions are checked against the scoreboard in issue order.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            n_tests = n_tests + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL resp_unexpected: got data=%h err=%b, required no response", resp_data, resp_error);
            end else begin
                mon_exp = sb.pop_front();
                if (resp_data !== mon_exp.data || resp_error !== mon_exp.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL resp_order: got data=%h err=%b, required data=%h err=%b",
                             resp_data, resp_error, mon_exp.data, mon_exp.err);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) cyc();
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0000 || resp_valid !== 1'b0 || resp_error !== 1'b0 ||
            resp_data !== 32'h0 || t_resp_ready !== 4'b0000 || req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_state: got tv=%b rv=%b re=%b rd=%h trr=%b rr=%b, required 0000 0 0 0 0000 1",
                     t_req_valid, resp_valid, resp_error, resp_data, t_resp_ready, req_ready);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_read_t0;
        t_req_ready = 4'b1111;
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_1004;
        req_write   = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (req_ready !== 1'b1 || req_uncachable !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL read_t0_req: got ready=%b unc=%b, required 1 0", req_ready, req_uncachable);
        end
        sb.push_back(mk(32'hDEADBEEF, 1'b0));
        cyc();
        req_valid = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0001 || t_req_addr !== 32'h0000_1004 || t_req_write !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL read_t0_fwd: got tv=%b addr=%h wr=%b, required 0001 00001004 0",
                     t_req_valid, t_req_addr, t_req_write);
        end
        cyc();
        t_resp_valid      = 4'b0001;
        t_resp_data[31:0] = 32'hDEADBEEF;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0000 || resp_valid !== 1'b1 || t_resp_ready !== 4'b0001) begin
            n_fail = n_fail + 1;
            $display("FAIL read_t0_resp: got tv=%b rv=%b trr=%b, required 0000 1 0001",
                     t_req_valid, resp_valid, t_resp_ready);
        end
        cyc();
        t_resp_valid = 4'b0000;
    endtask

    task automatic test_write_t1;
        req_valid = 1'b1;
        req_addr  = 32'h0200_4000;
        req_write = 1'b1;
        req_wdata = 32'h0000_0005;
        req_wstrb = 4'hF;
        #1;
        n_tests = n_tests + 1;
        if (req_uncachable !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL write_t1_unc: got %b, required 1", req_uncachable);
        end
        sb.push_back(mk(32'h1234_5678, 1'b0));
        cyc();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0010 || t_req_addr !== 32'h0200_4000 || t_req_write !== 1'b1 ||
            t_req_wdata !== 32'h5 || t_req_wstrb !== 4'hF) begin
            n_fail = n_fail + 1;
            $display("FAIL write_t1_fwd: got tv=%b addr=%h wr=%b wd=%h ws=%h, required 0010 02004000 1 00000005 f",
                     t_req_valid, t_req_addr, t_req_write, t_req_wdata, t_req_wstrb);
        end
        t_resp_valid       = 4'b0010;
        t_resp_data[63:32] = 32'h1234_5678;
        cyc();
        t_resp_valid = 4'b0000;
    endtask

    task automatic test_unmapped;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h4000_0000;
        #1;
        n_tests = n_tests + 1;
        if (req_uncachable !== 1'b1 || req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL unmapped_req: got unc=%b ready=%b, required 1 1", req_uncachable, req_ready);
        end
        sb.push_back(mk(32'h0, 1'b1));
        cyc();
        req_valid = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0000 || resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_data !== 32'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL unmapped_resp: got tv=%b rv=%b re=%b rd=%h, required 0000 1 1 0",
                     t_req_valid, resp_valid, resp_error, resp_data);
        end
        resp_ready = 1'b1;
        cyc();
        #1;
        n_tests = n_tests + 1;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL unmapped_pop: got rv=%b re=%b, required 0 0", resp_valid, resp_error);
        end
    endtask

    task automatic test_back_to_back;
        t_req_ready = 4'b1111;
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h8000_0000;
        sb.push_back(mk(32'hAAAA_2222, 1'b0));
        cyc();
        req_addr = 32'h1000_0000;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0100 || req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_first: got tv=%b ready=%b, required 0100 1", t_req_valid, req_ready);
        end
        sb.push_back(mk(32'hBBBB_3333, 1'b0));
        cyc();
        req_valid = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b1000) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_second: got tv=%b, required 1000", t_req_valid);
        end
        t_resp_valid         = 4'b1000;
        t_resp_data[127:96]  = 32'hBBBB_3333;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests = n_tests + 1;
            if (t_resp_ready[3] !== 1'b0 || resp_valid !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_stall: got trr3=%b rv=%b, required 0 0", t_resp_ready[3], resp_valid);
            end
            cyc();
        end
        t_resp_valid        = 4'b1100;
        t_resp_data[95:64]  = 32'hAAAA_2222;
        #1;
        n_tests = n_tests + 1;
        if (t_resp_ready !== 4'b0100 || resp_data !== 32'hAAAA_2222) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_head2: got trr=%b rd=%h, required 0100 aaaa2222", t_resp_ready, resp_data);
        end
        cyc();
        t_resp_valid = 4'b1000;
        #1;
        n_tests = n_tests + 1;
        if (t_resp_ready !== 4'b1000 || resp_data !== 32'hBBBB_3333) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_head3: got trr=%b rd=%h, required 1000 bbbb3333", t_resp_ready, resp_data);
        end
        cyc();
        t_resp_valid = 4'b0000;
    endtask

    task automatic test_fifo_full;
        t_req_ready = 4'b1111;
        resp_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_1000 + 32'(4 * i);
            sb.push_back(mk(32'hC0DE_0000 + 32'(i), 1'b0));
            cyc();
        end
        req_valid = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (req_ready !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL full_ready: got %b, required 0", req_ready);
        end
        t_resp_valid      = 4'b0001;
        t_resp_data[31:0] = 32'hC0DE_0000;
        resp_ready        = 1'b1;
        #1;
        n_tests = n_tests + 1;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL full_same_cycle_pop: got ready=%b rv=%b, required 0 1", req_ready, resp_valid);
        end
        cyc();
        resp_ready   = 1'b0;
        t_resp_valid = 4'b0000;
        #1;
        n_tests = n_tests + 1;
        if (req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL full_after_pop: got %b, required 1", req_ready);
        end
        for (int i = 1; i < 4; i++) begin
            t_resp_valid      = 4'b0001;
            t_resp_data[31:0] = 32'hC0DE_0000 + 32'(i);
            resp_ready        = 1'b1;
            cyc();
        end
        t_resp_valid = 4'b0000;
    endtask

    task automatic test_stall_reset;
        t_req_ready = 4'b1110;
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_1008;
        req_write   = 1'b1;
        req_wdata   = 32'hA5A5_A5A5;
        req_wstrb   = 4'h3;
        sb.push_back(mk(32'h0, 1'b0));
        cyc();
        req_addr  = 32'h0000_1100;
        req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests = n_tests + 1;
            if (t_req_valid !== 4'b0001 || t_req_addr !== 32'h0000_1008 || t_req_wdata !== 32'hA5A5_A5A5 ||
                t_req_wstrb !== 4'h3 || req_ready !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL stall_hold: got tv=%b addr=%h wd=%h ws=%h ready=%b, required 0001 00001008 a5a5a5a5 3 0",
                         t_req_valid, t_req_addr, t_req_wdata, t_req_wstrb, req_ready);
            end
            cyc();
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        sb.delete();
        cyc();
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0000 || resp_valid !== 1'b0 || resp_error !== 1'b0 ||
            resp_data !== 32'h0 || t_resp_ready !== 4'b0000 || req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL stall_reset: got tv=%b rv=%b re=%b rd=%h trr=%b rr=%b, required 0000 0 0 0 0000 1",
                     t_req_valid, resp_valid, resp_error, resp_data, t_resp_ready, req_ready);
        end
        rst         = 1'b0;
        t_req_ready = 4'b1111;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_1004;
        sb.push_back(mk(32'h600D_F00D, 1'b0));
        cyc();
        req_valid = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (t_req_valid !== 4'b0001 || t_req_addr !== 32'h0000_1004 || t_req_write !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_fwd: got tv=%b addr=%h wr=%b, required 0001 00001004 0",
                     t_req_valid, t_req_addr, t_req_write);
        end
        cyc();
        t_resp_valid      = 4'b0001;
        t_resp_data[31:0] = 32'h600D_F00D;
        cyc();
        t_resp_valid = 4'b0000;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_write    = 1'b0;
        req_wdata    = 32'h0;
        req_wstrb    = 4'h0;
        resp_ready   = 1'b0;
        t_req_ready  = 4'b0000;
        t_resp_valid = 4'b0000;
        t_resp_data  = '0;

        test_reset();
        test_read_t0();
        test_write_t1();
        test_unmapped();
        test_back_to_back();
        test_fifo_full();
        test_stall_reset();

        repeat (3) cyc();
        n_tests = n_tests + 1;
        if (sb.size() != 0 || resp_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got pending=%0d rv=%b, required 0 0", sb.size(), resp_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
